// File: rtl/down_timer_pkg.sv
// down_timer_pkg: shared timer types and defaults.
//   state_t       - FSM state, 1-bit encoding (IDLE, RUN)
//   DEFAULT_WIDTH - default counter / load-value width
package timer_pkg;
    localparam int DEFAULT_WIDTH = 4;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/down_timer_if.sv
// down_timer_if: control/status bundle of the down timer.
//   master drives load, load_val, start, stop, auto_reload; reads q, busy, done, zero
//   slave  is the timer side of the same signals
import timer_pkg::*;
interface down_timer_if #(parameter int WIDTH = DEFAULT_WIDTH);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             stop;
    logic             auto_reload;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic             zero;
    modport master (output load, load_val, start, stop, auto_reload,
                    input  q, busy, done, zero);
    modport slave  (input  load, load_val, start, stop, auto_reload,
                    output q, busy, done, zero);
endinterface

// File: rtl/down_timer_count_reg.sv
// down_count_reg: falling-edge count register with async reset, load and decrement.
//   clk, reset    - clock (falling edge), async active-high reset
//   ld, ld_val    - synchronous load (wins over dec)
//   dec           - synchronous decrement enable
//   q, is_one     - current count and q == 1 flag
import timer_pkg::*;
module down_count_reg #(parameter int WIDTH = DEFAULT_WIDTH) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             dec,
    output logic [WIDTH-1:0] q,
    output logic             is_one
);
    always_ff @(negedge clk or posedge reset)
        if (reset)
            q <= '0;
        else if (ld)
            q <= ld_val;
        else if (dec)
            q <= q - WIDTH'(1);
    assign is_one = q == WIDTH'(1);
endmodule

// File: rtl/down_timer.sv
// down_timer: programmable down-counting timer with terminal-count pulse and auto-reload.
//   clk, reset - falling-edge clock, async active-high reset
//   bus        - slave side of down_timer_if (load/start/stop/auto_reload in;
//                q, busy, done, zero out)
import timer_pkg::*;
module down_timer #(parameter int WIDTH = DEFAULT_WIDTH) (
    input logic         clk,
    input logic         reset,
    down_timer_if.slave bus
);
    state_t           state;
    logic [WIDTH-1:0] reload_reg;
    logic [WIDTH-1:0] q;
    logic             is_one;
    logic             run;
    logic             counting;
    logic             reload_ok;
    logic             cnt_ld;
    logic             cnt_dec;
    logic             done_r;
    assign run       = state == RUN;
    assign counting  = run && !bus.load && !bus.stop;
    // A zero reload value cannot define a period, so it behaves as a one-shot.
    assign reload_ok = bus.auto_reload && reload_reg != '0;
    assign cnt_ld    = bus.load || (counting && is_one && reload_ok);
    // In RUN q is never 0 (zero start and zero loads leave RUN), so the q == 1
    // path of the decrement is the one-shot terminal step to 0.
    assign cnt_dec   = counting && !(is_one && reload_ok);
    down_count_reg #(.WIDTH(WIDTH)) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .ld     (cnt_ld),
        .ld_val (bus.load ? bus.load_val : reload_reg),
        .dec    (cnt_dec),
        .q      (q),
        .is_one (is_one)
    );
    always_ff @(negedge clk or posedge reset)
        if (reset) begin
            state      <= IDLE;
            reload_reg <= '0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (bus.load) begin
                reload_reg <= bus.load_val;
                if (run && bus.load_val == '0)
                    state <= IDLE;
            end else if (bus.stop) begin
                state <= IDLE;
            end else if (run) begin
                if (is_one) begin
                    done_r <= 1'b1;
                    if (!reload_ok)
                        state <= IDLE;
                end
            end else if (bus.start) begin
                if (q == '0)
                    done_r <= 1'b1;
                else
                    state <= RUN;
            end
        end
    assign bus.q    = q;
    assign bus.busy = run;
    assign bus.done = done_r;
    assign bus.zero = q == '0;
endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: table-driven directed check of down_timer plus multi-cycle corner sequences.
module tb_down_timer;
    typedef struct {
        logic       ld;
        logic [3:0] lv;
        logic       st;
        logic       sp;
        logic       ar;
        logic [3:0] eq;
        logic       eb;
        logic       ed;
        logic       ez;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    vec_t vecs[$];

    down_timer_if #(.WIDTH(4)) bus ();
    down_timer #(.WIDTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [3:0] eq, input logic eb, input logic ed, input logic ez);
        chk({name, ".q"}, 16'(bus.q), 16'(eq));
        chk({name, ".busy"}, 16'(bus.busy), 16'(eb));
        chk({name, ".done"}, 16'(bus.done), 16'(ed));
        chk({name, ".zero"}, 16'(bus.zero), 16'(ez));
    endtask

    task automatic drive(input logic ld, input logic [3:0] lv, input logic st, input logic sp, input logic ar);
        bus.load = ld;
        bus.load_val = lv;
        bus.start = st;
        bus.stop = sp;
        bus.auto_reload = ar;
    endtask

    // Outputs are sampled 2 time units after the active falling edge.
    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic add(input logic ld, input logic [3:0] lv, input logic st, input logic sp, input logic ar,
                       input logic [3:0] eq, input logic eb, input logic ed, input logic ez);
        vec_t v;
        v.ld = ld; v.lv = lv; v.st = st; v.sp = sp; v.ar = ar;
        v.eq = eq; v.eb = eb; v.ed = ed; v.ez = ez;
        vecs.push_back(v);
    endtask

    initial begin
        // start at zero
        add(0, 0, 1, 0, 0,  0, 0, 1, 1);
        add(0, 0, 0, 0, 0,  0, 0, 0, 1);
        // single shot from 5
        add(1, 5, 0, 0, 0,  5, 0, 0, 0);
        add(0, 0, 1, 0, 0,  5, 1, 0, 0);
        add(0, 0, 0, 0, 0,  4, 1, 0, 0);
        add(0, 0, 0, 0, 0,  3, 1, 0, 0);
        add(0, 0, 0, 0, 0,  2, 1, 0, 0);
        add(0, 0, 0, 0, 0,  1, 1, 0, 0);
        add(0, 0, 0, 0, 0,  0, 0, 1, 1);
        add(0, 0, 0, 0, 0,  0, 0, 0, 1);
        // auto-reload period 3, then drop auto_reload before terminal count
        add(1, 3, 0, 0, 1,  3, 0, 0, 0);
        add(0, 0, 1, 0, 1,  3, 1, 0, 0);
        add(0, 0, 0, 0, 1,  2, 1, 0, 0);
        add(0, 0, 0, 0, 1,  1, 1, 0, 0);
        add(0, 0, 0, 0, 1,  3, 1, 1, 0);
        add(0, 0, 0, 0, 1,  2, 1, 0, 0);
        add(0, 0, 0, 0, 1,  1, 1, 0, 0);
        add(0, 0, 0, 0, 1,  3, 1, 1, 0);
        add(0, 0, 0, 0, 1,  2, 1, 0, 0);
        add(0, 0, 1, 0, 1,  1, 1, 0, 0);
        add(0, 0, 0, 0, 0,  0, 0, 1, 1);
        // load in RUN
        add(1, 9, 0, 0, 0,  9, 0, 0, 0);
        add(0, 0, 1, 0, 0,  9, 1, 0, 0);
        add(0, 0, 0, 0, 0,  8, 1, 0, 0);
        add(0, 0, 0, 0, 0,  7, 1, 0, 0);
        add(1, 4, 0, 0, 0,  4, 1, 0, 0);
        add(0, 0, 0, 0, 0,  3, 1, 0, 0);
        add(0, 0, 0, 0, 0,  2, 1, 0, 0);
        add(0, 0, 0, 0, 0,  1, 1, 0, 0);
        add(0, 0, 0, 0, 0,  0, 0, 1, 1);
        // load 0 in RUN
        add(1, 9, 0, 0, 0,  9, 0, 0, 0);
        add(0, 0, 1, 0, 0,  9, 1, 0, 0);
        add(0, 0, 0, 0, 0,  8, 1, 0, 0);
        add(1, 0, 0, 0, 0,  0, 0, 0, 1);
        add(0, 0, 0, 0, 0,  0, 0, 0, 1);
        // stop and resume
        add(1, 6, 0, 0, 0,  6, 0, 0, 0);
        add(0, 0, 1, 0, 0,  6, 1, 0, 0);
        add(0, 0, 0, 0, 0,  5, 1, 0, 0);
        add(0, 0, 0, 0, 0,  4, 1, 0, 0);
        add(0, 0, 0, 1, 0,  4, 0, 0, 0);
        add(0, 0, 0, 0, 0,  4, 0, 0, 0);
        add(0, 0, 1, 0, 0,  4, 1, 0, 0);
        add(0, 0, 0, 0, 0,  3, 1, 0, 0);
        add(0, 0, 0, 0, 0,  2, 1, 0, 0);
        add(0, 0, 0, 0, 0,  1, 1, 0, 0);
        add(0, 0, 0, 0, 0,  0, 0, 1, 1);
        // stop beats start, load beats stop
        add(1, 2, 0, 1, 0,  2, 0, 0, 0);
        add(0, 0, 1, 1, 0,  2, 0, 0, 0);
        // auto-reload period 1
        add(1, 1, 0, 0, 1,  1, 0, 0, 0);
        add(0, 0, 1, 0, 1,  1, 1, 0, 0);
        add(0, 0, 0, 0, 1,  1, 1, 1, 0);
        add(0, 0, 0, 0, 1,  1, 1, 1, 0);
        add(0, 0, 0, 0, 0,  0, 0, 1, 1);
        add(0, 0, 0, 0, 0,  0, 0, 0, 1);

        drive(0, 0, 0, 0, 0);
        #3;
        chk_all("reset", 0, 0, 0, 1);
        tick();
        reset = 1'b0;
        tick();
        chk_all("post_reset", 0, 0, 0, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].sp, vecs[i].ar);
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].eq, vecs[i].eb, vecs[i].ed, vecs[i].ez);
        end

        // full range from 15 without wrap
        drive(1, 15, 0, 0, 0);
        tick();
        drive(0, 0, 1, 0, 0);
        tick();
        chk_all("full_start", 15, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        for (int k = 14; k >= 1; k--) begin
            tick();
            chk_all($sformatf("full_q%0d", k), 4'(k), 1, 0, 0);
        end
        tick();
        chk_all("full_end", 0, 0, 1, 1);

        // asynchronous reset mid-count at q = 8
        drive(1, 12, 0, 0, 0);
        tick();
        drive(0, 0, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) tick();
        chk_all("pre_reset", 8, 1, 0, 0);
        #1 reset = 1'b1;
        #1;
        chk_all("async_reset", 0, 0, 0, 1);
        #1 reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk_all($sformatf("after_reset%0d", k), 0, 0, 0, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
- Programmable down-counting timer. Loads a start value, counts down once per falling clock edge, and flags terminal count.
- Complements the team's ripple up-counter. It is the "count down to an event" end of the counter family, used for delays, timeouts and clock division.
- Fully synchronous to the clk falling edge. Internal flops do not ripple.

Parameters:
- WIDTH, 4, counter and load-value width in bits (legal range 2..16).

Ports:
- clk  input  1  timer clock; all state updates on the falling edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- load  input  1  load load_val into counter and reload register
- load_val  input  WIDTH  value captured on load
- start  input  1  begin counting from current q
- stop  input  1  abort count and hold q
- auto_reload  input  1  on terminal count, reload and keep running instead of stopping
- q  output  WIDTH  current count (registered)
- busy  output  1  high while in RUN
- done  output  1  registered one-cycle pulse at terminal count
- zero  output  1  combinational, q == 0

Behaviour:
- Reset (asynchronous, active-high): q=0, reload_reg=0, state=IDLE, busy=0, done=0, zero=1. Reset asserted mid-RUN aborts immediately and produces no done pulse.
- States: IDLE, RUN. busy = (state == RUN).
- Per-edge control priority: reset > load > stop > start/count.
- done defaults to 0 on every edge unless set by the rules below. It is therefore high for exactly one clk period (falling edge to falling edge).
- IDLE:
  - load: q <= load_val, reload_reg <= load_val; stay IDLE.
  - start with q != 0: state <= RUN. q is unchanged on this edge.
  - start with q == 0: done <= 1; stay IDLE.
  - Otherwise hold.
- RUN:
  - load: q <= load_val, reload_reg <= load_val, no done. If load_val == 0, go to IDLE; else stay RUN.
  - stop: state <= IDLE, q held, no done.
  - q > 1: q <= q - 1.
  - q == 1 and auto_reload == 0: q <= 0, done <= 1, state <= IDLE.
  - q == 1 and auto_reload == 1 and reload_reg != 0: q <= reload_reg, done <= 1, stay RUN. The period is reload_reg clocks.
  - q == 1 and auto_reload == 1 and reload_reg == 0: treated as auto_reload == 0.
  - start is ignored in RUN.
- Latency:
  - start sampled at edge N; first decrement at edge N+1.
  - done is asserted after edge N+q0, where q0 is the value of q at start.
- Arithmetic: unsigned WIDTH-bit. Decrement never wraps below 0, because the q == 1 rule intercepts it.
  - Example: load_val = 2^WIDTH-1 counts the full range without overflow.
- auto_reload is sampled only at the terminal-count edge. Changing it mid-count is legal.

Decomposition:
- Shared package timer_pkg:
  - state enum {IDLE, RUN} as a 1-bit encoding
  - default WIDTH constant
- Sub-module down_count_reg: WIDTH-bit register with async reset, synchronous load and decrement-enable, falling-edge clocked.
  - Outputs q and is_one (q == 1).
- Top-level down_timer holds the FSM, reload_reg, done flop and the zero/busy decode.

Test Plan:
- Load and single shot: reset, load_val=5, load, then start. Response: q steps 5,4,3,2,1,0 on consecutive falling edges after the start edge; done high only for the period following q → 0; busy falls on the same edge; zero=1 afterwards.
- Auto-reload: load_val=3, auto_reload=1, start, run 10 edges. Response: q sequence 3,2,1,3,2,1,3,...; done pulses every 3 clocks; busy stays 1.
- Start at zero: after reset (q=0), assert start. Response: done pulses once, state stays IDLE, busy=0, q=0.
- Load in RUN: load 9, start, after 2 decrements (q=7) load load_val=4. Response: q=4 on that edge, no done, counting continues 3,2,1,0 with done at 0. Repeat with load_val=0: q=0, IDLE, no done.
- Stop and resume: load 6, start, assert stop at q=4. Response: q holds 4, busy=0, no done. Then start: counts 3,2,1,0, done.
- Reset mid-operation: load 12, start, assert reset asynchronously between clock edges at q=8. Response: q=0, busy=0, done=0 immediately, before the next clk edge. No done after reset release.
